// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - looping pattern step sequencer driving a note code and gate
module step_sequencer #(
  parameter int STEPS = 16,
  parameter int CODE_W = 4,
  parameter int TEMPO_W = 26,
  parameter logic [STEPS*CODE_W-1:0] INIT_PATTERN = '0,
  localparam int STEP_W = $clog2(STEPS)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               run,
  input  logic [TEMPO_W-1:0] tempo_period,
  input  logic [TEMPO_W-1:0] gate_len,
  input  logic [STEP_W-1:0]  last_step,
  input  logic               wr_en,
  input  logic [STEP_W-1:0]  wr_addr,
  input  logic [CODE_W-1:0]  wr_data,
  output logic [STEP_W-1:0]  step,
  output logic [CODE_W-1:0]  note_code,
  output logic               note_on,
  output logic               step_pulse
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t state, state_nxt;

  logic [CODE_W-1:0]  pattern [STEPS];

  // Per-step timing, latched at each step start
  logic [TEMPO_W-1:0] tick, tick_nxt;
  logic [TEMPO_W-1:0] period, period_nxt;
  logic [TEMPO_W-1:0] gate, gate_nxt;

  logic [STEP_W-1:0]  step_nxt;
  logic [CODE_W-1:0]  code_nxt;
  logic               on_nxt;
  logic               pulse_nxt;

  logic [STEP_W-1:0]  last_eff;
  logic [STEP_W-1:0]  adv_idx;
  logic [STEP_W-1:0]  load_idx;
  logic [CODE_W-1:0]  load_code;
  logic [TEMPO_W-1:0] period_in;
  logic               step_end;
  logic               start;
  logic               write_ok;

  // Resolve loop bound, next step index and the code to load (with write-through)
  always_comb begin
    last_eff  = (32'(last_step) > 32'(STEPS - 1)) ? STEP_W'(STEPS - 1) : last_step;
    adv_idx   = (step >= last_eff) ? '0 : step + STEP_W'(1);
    load_idx  = (state == PLAY) ? adv_idx : '0;
    load_code = (wr_en && (wr_addr == load_idx)) ? wr_data : pattern[load_idx];
    period_in = (tempo_period < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo_period;
    step_end  = (tick == period - TEMPO_W'(1));
    start     = run && ((state == IDLE) || step_end);
    write_ok  = wr_en && (32'(wr_addr) < 32'(STEPS));
  end

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: run level alone moves between IDLE and PLAY
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run)  state_nxt = PLAY;
      PLAY:    if (!run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values; note_on is computed from the next tick so it stays registered
  always_comb begin
    tick_nxt   = tick;
    period_nxt = period;
    gate_nxt   = gate;
    step_nxt   = step;
    code_nxt   = note_code;
    on_nxt     = 1'b0;
    pulse_nxt  = 1'b0;
    if (start) begin
      tick_nxt   = '0;
      period_nxt = period_in;
      gate_nxt   = gate_len;
      step_nxt   = load_idx;
      code_nxt   = load_code;
      pulse_nxt  = 1'b1;
      on_nxt     = (load_code != '0) && (gate_len != '0);
    end else if (state == PLAY) begin
      if (!run) begin
        // Stop: clear position, keep the last code visible
        tick_nxt = '0;
        step_nxt = '0;
      end else begin
        tick_nxt = tick + TEMPO_W'(1);
        on_nxt   = (note_code != '0) && (tick_nxt < gate);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick       <= '0;
      period     <= TEMPO_W'(2);
      gate       <= '0;
      step       <= '0;
      note_code  <= '0;
      note_on    <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      tick       <= tick_nxt;
      period     <= period_nxt;
      gate       <= gate_nxt;
      step       <= step_nxt;
      note_code  <= code_nxt;
      note_on    <= on_nxt;
      step_pulse <= pulse_nxt;
    end
  end

  // Pattern storage: reset reloads the initial pattern and discards any concurrent write
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) begin
        pattern[i] <= INIT_PATTERN[i*CODE_W +: CODE_W];
      end
    end else if (write_ok) begin
      pattern[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - scoreboard bench for step_sequencer
module tb_step_sequencer;

  localparam logic [63:0] INIT = 64'hFEDC_BA98_7654_3210;

  logic        CLOCK_50 = 1'b0;
  logic        reset, run, wr_en;
  logic [25:0] tempo_period, gate_len;
  logic [3:0]  last_step, wr_addr, wr_data;
  logic [3:0]  step, note_code;
  logic        note_on, step_pulse;

  step_sequencer #(
    .STEPS(16), .CODE_W(4), .TEMPO_W(26), .INIT_PATTERN(INIT)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .run(run),
    .tempo_period(tempo_period), .gate_len(gate_len), .last_step(last_step),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .step(step), .note_code(note_code), .note_on(note_on), .step_pulse(step_pulse)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [3:0] step;
    logic [3:0] code;
    logic       on;
    logic       pulse;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  int m_play, m_step, m_tick, m_per, m_gate, m_code, m_on, m_pulse;
  int m_pat [16];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic m_load(input int s);
    m_play  = 1;
    m_step  = s;
    m_tick  = 0;
    m_per   = (tempo_period < 2) ? 2 : int'(tempo_period);
    m_gate  = int'(gate_len);
    m_code  = (wr_en && int'(wr_addr) == s) ? int'(wr_data) : m_pat[s];
    m_pulse = 1;
    m_on    = (m_code != 0 && m_gate > 0) ? 1 : 0;
  endtask

  // Reference behaviour for one clock edge, using the inputs about to be sampled
  task automatic model_step();
    int lst;
    lst = (int'(last_step) > 15) ? 15 : int'(last_step);
    if (reset) begin
      m_play = 0; m_step = 0; m_tick = 0; m_code = 0; m_on = 0; m_pulse = 0;
      for (int i = 0; i < 16; i++) m_pat[i] = int'(INIT[i*4 +: 4]);
    end else begin
      if (m_play == 0) begin
        if (run) m_load(0);
      end else if (!run) begin
        m_play = 0; m_on = 0; m_pulse = 0; m_tick = 0; m_step = 0;
      end else if (m_tick == m_per - 1) begin
        m_load((m_step >= lst) ? 0 : m_step + 1);
      end else begin
        m_tick++;
        m_pulse = 0;
        m_on = (m_code != 0 && m_tick < m_gate) ? 1 : 0;
      end
      if (wr_en) m_pat[wr_addr] = int'(wr_data);
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    e.step  = 4'(m_step);
    e.code  = 4'(m_code);
    e.on    = m_on[0];
    e.pulse = m_pulse[0];
    sb.push_back(e);
    @(posedge CLOCK_50);
    #1;
    e = sb.pop_front();
    check_val("step", 32'(step), 32'(e.step));
    check_val("note_code", 32'(note_code), 32'(e.code));
    check_val("note_on", 32'(note_on), 32'(e.on));
    check_val("step_pulse", 32'(step_pulse), 32'(e.pulse));
  endtask

  // Advance until a step start at step s (any step when s < 0)
  task automatic wait_pulse(input int s);
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (step_pulse && (s < 0 || int'(step) == s)) return;
    end
    check_val("wait_pulse_timeout", 0, 1);
  endtask

  task automatic measure_gap(output int g);
    g = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      g++;
      if (step_pulse) return;
    end
    g = -1;
    check_val("gap_timeout", 0, 1);
  endtask

  initial begin
    int seq, gap, on_cnt, prev_code, cnt, maxs, g;
    reset = 1; run = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    tempo_period = 10; gate_len = 4; last_step = 15;
    cycle();
    cycle();
    check_val("rst_step", 32'(step), 0);
    check_val("rst_code", 32'(note_code), 0);
    check_val("rst_pulse", 32'(step_pulse), 0);
    reset = 0;

    // Load codes: step i gets (i+1) mod 16
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_addr = 4'(i); wr_data = 4'((i + 1) % 16);
      cycle();
    end
    wr_en = 0;
    cycle();
    check_val("idle_no_pulse", 32'(step_pulse), 0);

    // Basic playback, P=10 gate=4
    run = 1;
    cycle();
    check_val("first_pulse", 32'(step_pulse), 1);
    check_val("first_step", 32'(step), 0);
    check_val("first_code", 32'(note_code), 1);
    seq = 0; gap = 0; on_cnt = int'(note_on); prev_code = int'(note_code);
    repeat (169) begin
      cycle();
      gap++;
      if (step_pulse) begin
        check_val("pulse_gap", 32'(gap), 10);
        seq = (seq + 1) % 16;
        check_val("step_seq", 32'(step), 32'(seq));
        check_val("gate_cnt", 32'(on_cnt), (prev_code != 0) ? 4 : 0);
        gap = 0; on_cnt = 0; prev_code = int'(note_code);
      end
      if (note_on) on_cnt++;
    end
    check_val("wrap_step", 32'(step), 0);

    // Legato and silence
    gate_len = 10;
    repeat (40) cycle();
    gate_len = 15;
    repeat (40) cycle();
    gate_len = 0;
    wait_pulse(-1);
    cnt = int'(note_on);
    repeat (30) begin
      cycle();
      if (note_on) cnt++;
    end
    check_val("gate0_silent", 32'(cnt), 0);

    // Shrink the loop while sounding step 6
    gate_len = 4;
    wait_pulse(6);
    last_step = 3;
    wait_pulse(-1);
    check_val("shrink_wrap", 32'(step), 0);
    maxs = 0;
    repeat (60) begin
      cycle();
      if (int'(step) > maxs) maxs = int'(step);
    end
    check_val("loop_max", 32'(maxs), 3);

    // Mid-step tempo change, then clamp of period 1
    wait_pulse(-1);
    cycle();
    cycle();
    tempo_period = 4;
    measure_gap(g);
    check_val("tempo_hold", 32'(2 + g), 10);
    measure_gap(g);
    check_val("tempo_new", 32'(g), 4);
    tempo_period = 1;
    measure_gap(g);
    check_val("tempo_latched", 32'(g), 4);
    measure_gap(g);
    check_val("tempo_min", 32'(g), 2);

    // Write-through on the loading edge, and write to the sounding step
    tempo_period = 10;
    last_step = 15;
    measure_gap(g);
    wait_pulse(1);
    repeat (9) cycle();
    wr_en = 1; wr_addr = 2; wr_data = 9;
    cycle();
    wr_en = 0;
    check_val("wt_step", 32'(step), 2);
    check_val("wt_code", 32'(note_code), 9);
    cycle();
    cycle();
    wr_en = 1; wr_addr = 2; wr_data = 5;
    cycle();
    wr_en = 0;
    check_val("cur_write_hold", 32'(note_code), 9);
    wait_pulse(2);
    check_val("cur_write_next", 32'(note_code), 5);

    // Stop mid-step and restart
    repeat (3) cycle();
    run = 0;
    cycle();
    check_val("stop_on", 32'(note_on), 0);
    check_val("stop_step", 32'(step), 0);
    repeat (5) cycle();
    run = 1;
    cycle();
    check_val("restart_pulse", 32'(step_pulse), 1);
    check_val("restart_step", 32'(step), 0);

    // Reset mid-play with a concurrent write
    repeat (5) cycle();
    reset = 1; wr_en = 1; wr_addr = 3; wr_data = 7;
    cycle();
    reset = 0; wr_en = 0;
    check_val("mid_rst_step", 32'(step), 0);
    check_val("mid_rst_code", 32'(note_code), 0);
    check_val("mid_rst_on", 32'(note_on), 0);
    check_val("mid_rst_pulse", 32'(step_pulse), 0);
    tempo_period = 4; gate_len = 10;
    wait_pulse(3);
    check_val("init_pat", 32'(note_code), 3);
    repeat (20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
